// File: rtl/jtag_dma_pkg.sv
// Shared encodings for the JTAG chain-1 DMA engine: FSM states, launch command record,
// burst limits and the burst-length clip helper.
package jtag_dma_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_GRANT = 3'd2;
   localparam logic [2:0] ST_BEGIN = 3'd3;
   localparam logic [2:0] ST_DATA  = 3'd4;
   localparam logic [2:0] ST_END   = 3'd5;
   localparam logic [2:0] ST_GAP   = 3'd6;
   localparam logic [2:0] ST_DONE  = 3'd7;

   localparam int          MAX_BURST = 256;
   localparam int          BEAT_W    = $clog2(MAX_BURST) + 1;
   localparam logic [31:0] ADDR_INC  = 32'd4;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [7:0]  burst;
      logic [7:0]  block;
      logic        rd;
      logic        sw;
   } dma_cmd_t;

   // burst_size+1 can reach MAX_BURST, so compare in BEAT_W bits before clipping
   function automatic logic [7:0] clip_len(input logic [7:0] burst_size,
                                           input logic [7:0] words_left);
      logic [BEAT_W-1:0] beats;
      beats = {1'b0, burst_size} + 9'd1;
      clip_len = (beats > {1'b0, words_left}) ? words_left : beats[7:0];
   endfunction

endpackage

// File: rtl/dma_burst_counter.sv
// Tracks words left/done for a block and beats within the current burst; the burst
// length is clipped and frozen at burst start so the bus sees a stable size.
module dma_burst_counter
   import jtag_dma_pkg::*;
(
   input  logic       system_clk,
   input  logic       n_reset,
   input  logic       load,
   input  logic [7:0] block_size,
   input  logic [7:0] burst_size,
   input  logic       start,
   input  logic       beat,
   output logic [7:0] cur_len,
   output logic [7:0] words_left,
   output logic [7:0] words_done,
   output logic       last_beat
);

   logic [7:0] beat_cnt;

   assign last_beat = (beat_cnt == cur_len - 8'd1);

   always_ff @(posedge system_clk or negedge n_reset) begin
      if (!n_reset) begin
         cur_len    <= '0;
         words_left <= '0;
         words_done <= '0;
         beat_cnt   <= '0;
      end else if (load) begin
         cur_len    <= '0;
         words_left <= block_size;
         words_done <= '0;
         beat_cnt   <= '0;
      end else if (start) begin
         cur_len  <= clip_len(burst_size, words_left);
         beat_cnt <= '0;
      end else if (beat) begin
         beat_cnt   <= beat_cnt + 8'd1;
         words_left <= words_left - 8'd1;
         words_done <= words_done + 8'd1;
      end
   end

endmodule

// File: rtl/jtag_dma_controller.sv
// System-clock DMA engine moving words between the DMA half of the ping-pong buffer
// and the system bus in bursts. Optional macro JTAG_DMA_ERROR_EN enables bus_error abort.
module jtag_dma_controller
   import jtag_dma_pkg::*;
#(
   parameter int BUF_AW   = 8,
   parameter int GRANT_TO = 1024
) (
   input  logic              system_clk,
   input  logic              n_reset,
   input  logic              launch_write,
   input  logic              launch_read,
   input  logic              launch_switch,
   input  logic [31:0]       dma_address,
   input  logic [3:0]        dma_byte_enable,
   input  logic [7:0]        dma_burst_size,
   input  logic [7:0]        dma_block_size,
   output logic              dma_busy,
   output logic [7:0]        block_size_out,
   output logic [BUF_AW:0]   pp_address,
   output logic              pp_write_enable,
   output logic [31:0]       pp_data_in,
   input  logic [31:0]       pp_data_out,
   output logic              bus_request,
   input  logic              bus_grant,
   output logic              bus_begin,
   output logic [31:0]       bus_addr_data,
   output logic [3:0]        bus_byte_en,
   output logic [7:0]        bus_burst_size,
   output logic              bus_read_n_write,
   output logic              bus_data_valid,
   output logic              bus_end,
   input  logic [31:0]       bus_data_in,
   input  logic              bus_data_valid_in,
   input  logic              bus_busy,
   input  logic              bus_error,
   output logic              dma_error
);

   localparam int TW = $clog2(GRANT_TO + 1);

   logic [2:0]        state;
   dma_cmd_t          cmd;
   logic [TW-1:0]     grant_timer;
   logic              aborted, bus_err_abort, timeout, beat, any_launch, load_cmd;
   logic              last_beat;
   logic [7:0]        cur_len, words_left, words_done;
   logic [BUF_AW-1:0] idx;

   assign any_launch = launch_write | launch_read | launch_switch;
   assign load_cmd   = (state == ST_IDLE) && any_launch;
   assign timeout    = (state == ST_GRANT) && !bus_grant && (grant_timer == TW'(GRANT_TO - 1));
   assign beat       = (state == ST_DATA) && !bus_err_abort &&
                       (cmd.rd ? bus_data_valid_in : !bus_busy);

`ifdef JTAG_DMA_ERROR_EN
   assign bus_err_abort = bus_error && ((state == ST_BEGIN) || (state == ST_DATA));

   always_ff @(posedge system_clk or negedge n_reset) begin
      if (!n_reset)                      dma_error <= 1'b0;
      else if (load_cmd)                 dma_error <= 1'b0;
      else if (timeout || bus_err_abort) dma_error <= 1'b1;
   end
`else
   logic unused_bus_error;
   assign unused_bus_error = bus_error;
   assign bus_err_abort    = 1'b0;
   assign dma_error        = 1'b0;
`endif

   dma_burst_counter u_cnt (
      .system_clk (system_clk),
      .n_reset    (n_reset),
      .load       (load_cmd),
      .block_size (dma_block_size),
      .burst_size (cmd.burst),
      .start      (state == ST_REQ),
      .beat       (beat),
      .cur_len    (cur_len),
      .words_left (words_left),
      .words_done (words_done),
      .last_beat  (last_beat)
   );

   always_ff @(posedge system_clk or negedge n_reset) begin
      if (!n_reset) begin
         state          <= ST_IDLE;
         cmd            <= '0;
         grant_timer    <= '0;
         aborted        <= 1'b0;
         dma_busy       <= 1'b0;
         block_size_out <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               dma_busy <= any_launch;
               aborted  <= 1'b0;
               if (any_launch) begin
                  cmd.addr  <= dma_address;
                  cmd.be    <= dma_byte_enable;
                  cmd.burst <= dma_burst_size;
                  cmd.block <= dma_block_size;
                  cmd.rd    <= !launch_write && launch_read;
                  cmd.sw    <= !launch_write && !launch_read;
                  state     <= (!launch_write && !launch_read) || (dma_block_size == 8'd0)
                               ? ST_DONE : ST_REQ;
               end
            end
            ST_REQ: begin
               grant_timer <= '0;
               state       <= ST_GRANT;
            end
            ST_GRANT: begin
               if (bus_grant) state <= ST_BEGIN;
               else if (timeout) begin
                  aborted <= 1'b1;
                  state   <= ST_DONE;
               end else grant_timer <= grant_timer + 1'b1;
            end
            ST_BEGIN: begin
               if (bus_err_abort) begin
                  aborted <= 1'b1;
                  state   <= ST_END;
               end else state <= ST_DATA;
            end
            ST_DATA: begin
               if (bus_err_abort) begin
                  aborted <= 1'b1;
                  state   <= ST_END;
               end else if (beat && last_beat) state <= ST_END;
            end
            ST_END: begin
               cmd.addr <= cmd.addr + 32'(cur_len) * ADDR_INC;
               state    <= (aborted || words_left == 8'd0) ? ST_DONE : ST_GAP;
            end
            ST_GAP:  state <= ST_REQ;
            default: begin
               block_size_out <= cmd.sw ? cmd.block : words_done;
               state          <= ST_IDLE;
            end
         endcase
      end
   end

   // Write beats look one word ahead so the 1-cycle buffer latency never bubbles the bus
   always_comb begin
      bus_request      = state inside {ST_REQ, ST_GRANT, ST_BEGIN, ST_DATA, ST_END};
      bus_begin        = (state == ST_BEGIN);
      bus_byte_en      = bus_begin ? cmd.be : 4'd0;
      bus_burst_size   = bus_begin ? cur_len - 8'd1 : 8'd0;
      bus_read_n_write = cmd.rd && (state inside {ST_BEGIN, ST_DATA, ST_END});
      bus_data_valid   = !cmd.rd && (state == ST_DATA);
      bus_end          = (state == ST_END);
      bus_addr_data    = bus_begin ? cmd.addr : (bus_data_valid ? pp_data_out : 32'd0);
      pp_write_enable  = cmd.rd && (state == ST_DATA) && bus_data_valid_in && !bus_err_abort;
      pp_data_in       = pp_write_enable ? bus_data_in : 32'd0;
      idx              = BUF_AW'(words_done + 8'(beat && !cmd.rd));
      pp_address       = (state == ST_IDLE) ? '0 : {1'b1, idx};
   end

endmodule

// File: tb/tb_jtag_dma_controller.sv
// Directed scoreboard bench for jtag_dma_controller: bus slave and ping-pong buffer
// models respond to the DUT, expected begins/beats/buffer writes are queued at launch.
module tb_jtag_dma_controller;

   logic        system_clk = 1'b0;
   logic        n_reset;
   logic        launch_write, launch_read, launch_switch;
   logic [31:0] dma_address;
   logic [3:0]  dma_byte_enable;
   logic [7:0]  dma_burst_size, dma_block_size;
   logic        dma_busy;
   logic [7:0]  block_size_out;
   logic [8:0]  pp_address;
   logic        pp_write_enable;
   logic [31:0] pp_data_in;
   logic [31:0] pp_data_out = 32'd0;
   logic        bus_request, bus_grant, bus_begin;
   logic [31:0] bus_addr_data;
   logic [3:0]  bus_byte_en;
   logic [7:0]  bus_burst_size;
   logic        bus_read_n_write, bus_data_valid, bus_end;
   logic [31:0] bus_data_in;
   logic        bus_data_valid_in, bus_busy, bus_error;
   logic        dma_error;

   logic        grant_en;
   int          passed = 0, total = 0;
   int          rd_beats = 0, rd_word = 0, wr_beats = 0, stall_done = 0;
   int          stall_at = -1, stall_base = 0, stall_len = 0;
   int          busy_cycles = 0, req_cycles = 0;
   logic [63:0] exp_begin[$], exp_pp[$];
   logic [31:0] exp_beat[$];

   always #5 system_clk = ~system_clk;

   jtag_dma_controller dut (
      .system_clk(system_clk), .n_reset(n_reset),
      .launch_write(launch_write), .launch_read(launch_read), .launch_switch(launch_switch),
      .dma_address(dma_address), .dma_byte_enable(dma_byte_enable),
      .dma_burst_size(dma_burst_size), .dma_block_size(dma_block_size),
      .dma_busy(dma_busy), .block_size_out(block_size_out),
      .pp_address(pp_address), .pp_write_enable(pp_write_enable),
      .pp_data_in(pp_data_in), .pp_data_out(pp_data_out),
      .bus_request(bus_request), .bus_grant(bus_grant), .bus_begin(bus_begin),
      .bus_addr_data(bus_addr_data), .bus_byte_en(bus_byte_en),
      .bus_burst_size(bus_burst_size), .bus_read_n_write(bus_read_n_write),
      .bus_data_valid(bus_data_valid), .bus_end(bus_end), .bus_data_in(bus_data_in),
      .bus_data_valid_in(bus_data_valid_in), .bus_busy(bus_busy),
      .bus_error(bus_error), .dma_error(dma_error)
   );

   function automatic logic [31:0] buf_word(input logic [8:0] a);
      return 32'hA500_0000 | {23'd0, a};
   endfunction

   function automatic logic [63:0] pack_begin(input logic [31:0] a, input logic [7:0] bsz,
                                              input logic rd, input logic [3:0] be);
      return {19'd0, rd, be, bsz, a};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Buffer model (1-cycle read latency) and bus slave
   always @(posedge system_clk) begin
      pp_data_out <= buf_word(pp_address);
      if (bus_begin && bus_read_n_write) rd_beats <= int'(bus_burst_size) + 1;
      else if (bus_data_valid_in) begin
         rd_beats <= rd_beats - 1;
         rd_word  <= rd_word + 1;
      end
      if (bus_data_valid && !bus_busy) wr_beats <= wr_beats + 1;
      if (bus_busy) stall_done <= stall_done + 1;
   end

   assign bus_grant         = grant_en && bus_request;
   assign bus_data_valid_in = (rd_beats != 0);
   assign bus_data_in       = 32'hD000_0000 + 32'(rd_word);
   assign bus_busy          = bus_data_valid && (wr_beats == stall_at) &&
                              ((stall_done - stall_base) < stall_len);
   assign bus_error         = 1'b0;

   // Monitor: pops the scoreboard whenever the DUT produces a bus or buffer event
   always @(negedge system_clk) begin
      if (n_reset) begin
         if (dma_busy) busy_cycles <= busy_cycles + 1;
         if (bus_request) req_cycles <= req_cycles + 1;
         if (bus_begin) begin
            if (exp_begin.size() == 0) chk("unexpected begin", {32'd0, bus_addr_data}, 64'd0);
            else chk("begin", pack_begin(bus_addr_data, bus_burst_size, bus_read_n_write,
                                         bus_byte_en), exp_begin.pop_front());
         end
         if (bus_data_valid && !bus_busy) begin
            if (exp_beat.size() == 0) chk("unexpected beat", {32'd0, bus_addr_data}, 64'd0);
            else chk("write beat", {32'd0, bus_addr_data}, {32'd0, exp_beat.pop_front()});
         end
         if (bus_data_valid && bus_busy && exp_beat.size() != 0)
            chk("held beat", {32'd0, bus_addr_data}, {32'd0, exp_beat[0]});
         if (pp_write_enable) begin
            if (exp_pp.size() == 0) chk("unexpected pp write", {23'd0, pp_address, pp_data_in}, 64'd0);
            else chk("pp write", {23'd0, pp_address, pp_data_in}, exp_pp.pop_front());
         end
      end
   end

   task automatic launch(input int kind, input logic [31:0] a, input logic [7:0] bsz,
                         input logic [7:0] blk, input logic [3:0] be);
      @(negedge system_clk);
      dma_address = a; dma_burst_size = bsz; dma_block_size = blk; dma_byte_enable = be;
      launch_write = (kind == 0); launch_read = (kind == 1); launch_switch = (kind == 2);
      @(negedge system_clk);
      launch_write = 1'b0; launch_read = 1'b0; launch_switch = 1'b0;
      chk("busy rise", {63'd0, dma_busy}, 64'd1);
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n = 0;
      while (dma_busy !== 1'b0 && n < limit) begin
         @(negedge system_clk);
         n++;
      end
      chk(tag, {63'd0, dma_busy}, 64'd0);
   endtask

   initial begin
      int b0, r0;
      n_reset = 1'b0; grant_en = 1'b1;
      launch_write = 1'b0; launch_read = 1'b0; launch_switch = 1'b0;
      dma_address = '0; dma_byte_enable = '0; dma_burst_size = '0; dma_block_size = '0;
      repeat (2) @(negedge system_clk);
      chk("rst busy", {63'd0, dma_busy}, 64'd0);
      chk("rst request", {63'd0, bus_request}, 64'd0);
      chk("rst block_size_out", {56'd0, block_size_out}, 64'd0);
      chk("rst pp_address", {55'd0, pp_address}, 64'd0);
      chk("rst bus_addr_data", {32'd0, bus_addr_data}, 64'd0);
      chk("rst dma_error", {63'd0, dma_error}, 64'd0);
      n_reset = 1'b1;

      // write block 4, burst 1 -> two 2-beat bursts; a read launch mid-transfer is ignored
      exp_begin.push_back(pack_begin(32'h100, 8'd1, 1'b0, 4'hF));
      exp_begin.push_back(pack_begin(32'h108, 8'd1, 1'b0, 4'hF));
      for (int i = 0; i < 4; i++) exp_beat.push_back(buf_word(9'(9'h100 + i)));
      launch(0, 32'h100, 8'd1, 8'd4, 4'hF);
      repeat (3) @(negedge system_clk);
      launch_read = 1'b1;
      @(negedge system_clk);
      launch_read = 1'b0;
      wait_idle("write4 idle", 100);
      chk("write4 block_size_out", {56'd0, block_size_out}, 64'd4);
      chk("write4 begins drained", 64'(exp_begin.size()), 64'd0);
      chk("write4 beats drained", 64'(exp_beat.size()), 64'd0);

      // read block 5, burst 3 -> bursts of 4 and 1 beats into pp index 0..4
      exp_begin.push_back(pack_begin(32'h2000, 8'd3, 1'b1, 4'h3));
      exp_begin.push_back(pack_begin(32'h2010, 8'd0, 1'b1, 4'h3));
      for (int i = 0; i < 5; i++)
         exp_pp.push_back({23'd0, 9'(9'h100 + i), 32'hD000_0000 + 32'(rd_word + i)});
      launch(1, 32'h2000, 8'd3, 8'd5, 4'h3);
      wait_idle("read5 idle", 100);
      chk("read5 block_size_out", {56'd0, block_size_out}, 64'd5);
      chk("read5 pp drained", 64'(exp_pp.size()), 64'd0);
      chk("read5 begins drained", 64'(exp_begin.size()), 64'd0);

      // write with a 3-cycle slave stall on the third beat
      stall_at = wr_beats + 2; stall_base = stall_done; stall_len = 3;
      exp_begin.push_back(pack_begin(32'h400, 8'd5, 1'b0, 4'hF));
      for (int i = 0; i < 6; i++) exp_beat.push_back(buf_word(9'(9'h100 + i)));
      launch(0, 32'h400, 8'd7, 8'd6, 4'hF);
      wait_idle("stall idle", 100);
      chk("stall cycles", 64'(stall_done - stall_base), 64'd3);
      chk("stall beats drained", 64'(exp_beat.size()), 64'd0);
      chk("stall block_size_out", {56'd0, block_size_out}, 64'd6);

      // switch: no bus traffic, two busy cycles
      b0 = busy_cycles; r0 = req_cycles;
      launch(2, 32'h0, 8'd0, 8'd7, 4'hF);
      wait_idle("switch idle", 20);
      chk("switch busy cycles", 64'(busy_cycles - b0), 64'd2);
      chk("switch requests", 64'(req_cycles - r0), 64'd0);
      chk("switch block_size_out", {56'd0, block_size_out}, 64'd7);

      // grant withheld -> abort after 1024 waiting cycles
      grant_en = 1'b0;
      b0 = busy_cycles;
      launch(0, 32'h40, 8'd0, 8'd2, 4'hF);
      wait_idle("timeout idle", 1100);
      chk("timeout busy cycles", 64'(busy_cycles - b0), 64'd1027);
      chk("timeout block_size_out", {56'd0, block_size_out}, 64'd0);
`ifdef JTAG_DMA_ERROR_EN
      chk("timeout dma_error", {63'd0, dma_error}, 64'd1);
`else
      chk("timeout dma_error", {63'd0, dma_error}, 64'd0);
`endif
      grant_en = 1'b1;

      // reset in the middle of a write burst, then a fresh transfer
      exp_begin.push_back(pack_begin(32'h800, 8'd7, 1'b0, 4'hF));
      for (int i = 0; i < 8; i++) exp_beat.push_back(buf_word(9'(9'h100 + i)));
      launch(0, 32'h800, 8'd7, 8'd8, 4'hF);
      for (int n = 0; n < 50 && !bus_data_valid; n++) @(negedge system_clk);
      chk("mid-burst reached", {63'd0, bus_data_valid}, 64'd1);
      n_reset = 1'b0;
      #1;
      chk("mrst busy", {63'd0, dma_busy}, 64'd0);
      chk("mrst request", {63'd0, bus_request}, 64'd0);
      chk("mrst data_valid", {63'd0, bus_data_valid}, 64'd0);
      chk("mrst bus_addr_data", {32'd0, bus_addr_data}, 64'd0);
      chk("mrst pp_address", {55'd0, pp_address}, 64'd0);
      chk("mrst block_size_out", {56'd0, block_size_out}, 64'd0);
      exp_beat.delete();
      exp_begin.delete();
      @(negedge system_clk);
      n_reset = 1'b1;
      exp_begin.push_back(pack_begin(32'h20, 8'd0, 1'b0, 4'hF));
      exp_beat.push_back(buf_word(9'h100));
      launch(0, 32'h20, 8'd0, 8'd1, 4'hF);
      wait_idle("post-reset idle", 100);
      chk("post-reset block_size_out", {56'd0, block_size_out}, 64'd1);
      chk("post-reset beats drained", 64'(exp_beat.size()), 64'd0);
      chk("post-reset dma_error", {63'd0, dma_error}, 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
